// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, grant encoding and bus width.
package mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared data-memory port.
interface mem_port_arbiter_if;
  import mem_pkg::*;

  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_rdata;
  logic            i_ready;
  logic            i_stall;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_ready;
  logic            d_stall;

  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin winner select; req[0] is the I-side, req[1] the D-side.
module arb_rr2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output grant_e     winner
);

  always_comb begin
    winner = GRANT_I;
    if (req == 2'b11) begin
      // Under contention the side that was not served last goes next.
      winner = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req[1]) begin
      winner = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency data-memory port between instruction fetch and load/store,
// sequencing each access through IDLE -> BUSY (latency count) -> DONE (ready pulse).
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_DELAY = 3,
  parameter int CNT_W     = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_DELAY - 1);

  state_e          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  grant_e          last_grant_reg;
  grant_e          winner;
  logic            we_q_reg;
  logic [XLEN-1:0] mem_addr_reg;
  logic [XLEN-1:0] mem_wdata_reg;
  logic [XLEN-1:0] i_rdata_reg;
  logic [XLEN-1:0] d_rdata_reg;
  logic            accept;
  logic            capture;

  arb_rr2 u_arb (
    .req        ({bus.d_req, bus.i_req}),
    .last_grant (last_grant_reg),
    .winner     (winner)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      last_grant_reg <= GRANT_I;
      we_q_reg       <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      i_rdata_reg    <= '0;
      d_rdata_reg    <= '0;
    end else begin
      if (accept) begin
        cnt_reg        <= CNT_INIT;
        last_grant_reg <= winner;
        if (winner == GRANT_D) begin
          mem_addr_reg  <= bus.d_addr;
          mem_wdata_reg <= bus.d_wdata;
          we_q_reg      <= bus.d_we;
        end else begin
          mem_addr_reg <= bus.i_addr;
          we_q_reg     <= 1'b0;
        end
      end else if (state_reg == BUSY && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (capture) begin
        if (last_grant_reg == GRANT_D) begin
          d_rdata_reg <= bus.mem_rdata;
        end else begin
          i_rdata_reg <= bus.mem_rdata;
        end
      end
    end
  end

  // The strobe is decoded rather than registered so a store writes in exactly one cycle.
  assign bus.mem_we    = (state_reg == BUSY) && (cnt_reg == '0) && we_q_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.i_rdata   = i_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.i_ready   = (state_reg == DONE) && (last_grant_reg == GRANT_I);
  assign bus.d_ready   = (state_reg == DONE) && (last_grant_reg == GRANT_D);
  assign bus.i_stall   = bus.i_req && !bus.i_ready;
  assign bus.d_stall   = bus.d_req && !bus.d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester drivers, word memory model and an
// expected-completion queue checked cycle by cycle.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int MD = 3;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          side;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
    bit          we;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  int   we_cnt = 0;
  bit   ram_ready = 1'b0;
  logic [31:0] ram [0:63];

  req_t i_pend[$];
  req_t d_pend[$];
  exp_t sb[$];

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();

  mem_port_arbiter #(.MEM_DELAY(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_port_arbiter #(.MEM_DELAY(1), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  function automatic logic [31:0] exp_word(input logic [5:0] idx);
    if (idx == 6'd5) return 32'hDEADBEEF;
    return 32'h5A00_0000 | {26'h0, idx};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 64; k++) ram[k] <= exp_word(k[5:0]);
      ram_ready <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata  = ram[bus.mem_addr[7:2]];
  assign bus1.mem_rdata = exp_word(bus1.mem_addr[7:2]);

  always @(negedge clk) if (bus.mem_we === 1'b1) we_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic add_req(input bit side, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    if (side) d_pend.push_back(r);
    else      i_pend.push_back(r);
  endtask

  task automatic push_exp(input bit side, input logic [31:0] addr, input logic [31:0] data,
                          input bit chk, input bit we, input int due);
    exp_t e;
    e.side = side; e.addr = addr; e.data = data; e.chk = chk; e.we = we; e.due = due;
    sb.push_back(e);
  endtask

  // A requester presents its next pending access, or drops its request when none is left.
  task automatic present(input bit side);
    req_t r;
    if (!side) begin
      if (i_pend.size() > 0) begin
        r = i_pend.pop_front();
        bus.i_req = 1'b1; bus.i_addr = r.addr;
      end else begin
        bus.i_req = 1'b0;
      end
    end else begin
      if (d_pend.size() > 0) begin
        r = d_pend.pop_front();
        bus.d_req = 1'b1; bus.d_we = r.we; bus.d_addr = r.addr; bus.d_wdata = r.wdata;
      end else begin
        bus.d_req = 1'b0; bus.d_we = 1'b0;
      end
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 for the expected due times.
  task automatic run(input int budget);
    int   t0, rel, n;
    bit   ei, ed, ri, rd;
    exp_t e;
    t0 = cyc;
    n  = 0;
    if (!bus.i_req) present(1'b0);
    if (!bus.d_req) present(1'b1);
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      rel = cyc - t0;
      ei = (sb[0].side == 1'b0) && (sb[0].due == rel);
      ed = (sb[0].side == 1'b1) && (sb[0].due == rel);
      check("i_ready", 32'(bus.i_ready), 32'(ei));
      check("d_ready", 32'(bus.d_ready), 32'(ed));
      check("i_stall", 32'(bus.i_stall), 32'(bus.i_req && !ei));
      check("d_stall", 32'(bus.d_stall), 32'(bus.d_req && !ed));
      check("mem_we", 32'(bus.mem_we), 32'(sb[0].we && (rel == sb[0].due - 1)));
      if (rel == sb[0].due - MD || rel == sb[0].due - 1)
        check("mem_addr", bus.mem_addr, sb[0].addr);
      ri = bus.i_ready;
      rd = bus.d_ready;
      if (ei || ed) begin
        e = sb.pop_front();
        if (e.chk) check(ed ? "d_rdata" : "i_rdata", ed ? bus.d_rdata : bus.i_rdata, e.data);
        $display("txn side=%s we=%0d addr=%h rdata=%h rel_cycle=%0d",
                 ed ? "D" : "I", e.we, e.addr, ed ? bus.d_rdata : bus.i_rdata, rel);
      end
      @(posedge clk);
      #1;
      if (ri) present(1'b0);
      if (rd) present(1'b1);
      n++;
    end
    check("queue_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int wc0;
    bit r1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0;

    idle(3);
    check("rst_i_ready", 32'(bus.i_ready), 32'd0);
    check("rst_d_ready", 32'(bus.d_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Contention straight after reset: D first, then I.
    add_req(1'b0, 1'b0, 32'h30, '0);
    add_req(1'b1, 1'b0, 32'h34, '0);
    push_exp(1'b1, 32'h34, exp_word(6'd13), 1'b1, 1'b0, 4);
    push_exp(1'b0, 32'h30, exp_word(6'd12), 1'b1, 1'b0, 9);
    run(40);
    idle(2);

    // Sustained contention: grants alternate D, I, D, I.
    add_req(1'b1, 1'b0, 32'h48, '0);
    add_req(1'b1, 1'b0, 32'h4C, '0);
    add_req(1'b0, 1'b0, 32'h40, '0);
    add_req(1'b0, 1'b0, 32'h44, '0);
    push_exp(1'b1, 32'h48, exp_word(6'd18), 1'b1, 1'b0, 4);
    push_exp(1'b0, 32'h40, exp_word(6'd16), 1'b1, 1'b0, 9);
    push_exp(1'b1, 32'h4C, exp_word(6'd19), 1'b1, 1'b0, 14);
    push_exp(1'b0, 32'h44, exp_word(6'd17), 1'b1, 1'b0, 19);
    run(60);
    idle(2);

    // Single D load.
    add_req(1'b1, 1'b0, 32'h14, '0);
    push_exp(1'b1, 32'h14, 32'hDEADBEEF, 1'b1, 1'b0, 4);
    run(40);
    idle(2);

    // Single D store: one strobe, memory updated.
    wc0 = we_cnt;
    add_req(1'b1, 1'b1, 32'h8, 32'h12345678);
    push_exp(1'b1, 32'h8, '0, 1'b0, 1'b1, 4);
    run(40);
    idle(1);
    check("store_strobes", 32'(we_cnt - wc0), 32'd1);
    check("store_ram", ram[2], 32'h12345678);
    idle(1);

    // Reset in cycle 2 of a store.
    wc0 = we_cnt;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'hCAFEF00D;
    idle(2);
    check("mem_addr_pre_rst", bus.mem_addr, 32'h20);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mid_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_d_ready", 32'(bus.d_ready), 32'd0);
    check("rst_mid_d_rdata", bus.d_rdata, 32'd0);
    check("rst_mid_i_rdata", bus.i_rdata, 32'd0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    idle(3);
    check("rst_mid_strobes", 32'(we_cnt - wc0), 32'd0);
    check("rst_mid_ram", ram[8], exp_word(6'd8));
    rst_n = 1'b1;
    idle(1);
    add_req(1'b1, 1'b0, 32'h20, '0);
    push_exp(1'b1, 32'h20, exp_word(6'd8), 1'b1, 1'b0, 4);
    run(40);
    idle(2);

    // MEM_DELAY=1 build: load ready two cycles after the request.
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h14;
    for (int rel = 0; rel < 4; rel++) begin
      @(negedge clk);
      check("md1_d_ready", 32'(bus1.d_ready), 32'(rel == 2));
      if (rel == 1) check("md1_mem_addr", bus1.mem_addr, 32'h14);
      if (rel == 2) begin
        check("md1_d_rdata", bus1.d_rdata, 32'hDEADBEEF);
        $display("txn side=D md1 addr=%h rdata=%h rel_cycle=%0d", bus1.d_addr, bus1.d_rdata, rel);
      end
      r1 = bus1.d_ready;
      @(posedge clk);
      #1;
      if (r1) bus1.d_req = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
